// File: rtl/y8960_mem_arbiter.sv
// Arbitrates the cartridge's external byte-wide memory between the slot-side bus port and the loader port.
// Optional ROM write protection for slot writes below 0x40000 is enabled by defining Y8960_MEMARB_ROMWP_EN.
module y8960_mem_arbiter #(
    parameter int LOAD_MAXWAIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST_n,
    input  logic        i_SLOT_RQ,
    input  logic        i_SLOT_WR,
    input  logic [18:0] i_SLOT_ADDR,
    input  logic [7:0]  i_SLOT_WDATA,
    output logic [7:0]  o_SLOT_RDATA,
    output logic        o_SLOT_DONE,
    output logic        o_SLOT_OVF,
    input  logic        i_LD_VALID,
    output logic        o_LD_READY,
    input  logic        i_LD_WR,
    input  logic [18:0] i_LD_ADDR,
    input  logic [7:0]  i_LD_WDATA,
    output logic [7:0]  o_LD_RDATA,
    output logic        o_LD_RVALID,
    output logic        o_MEM_RQ,
    output logic        o_MEM_WR,
    output logic [18:0] o_MEM_ADDR,
    output logic [7:0]  o_MEM_WDATA,
    input  logic [7:0]  i_MEM_RDATA,
    input  logic        i_MEM_RDY,
    output logic        o_BUSY,
    output logic        o_ERR
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(LOAD_MAXWAIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LOAD_MAXWAIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          pend_q, pend_d;
    logic          pend_wr_q, pend_wr_d;
    logic [18:0]   pend_addr_q, pend_addr_d;
    logic [7:0]    pend_wdata_q, pend_wdata_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          owner_ld_q, owner_ld_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_rq_q, mem_rq_d;
    logic          mem_wr_q, mem_wr_d;
    logic [18:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [7:0]    slot_rdata_q, slot_rdata_d;
    logic          slot_done_q, slot_done_d;
    logic          slot_ovf_q, slot_ovf_d;
    logic [7:0]    ld_rdata_q, ld_rdata_d;
    logic          ld_ready_q, ld_ready_d;
    logic          ld_rvalid_q, ld_rvalid_d;
    logic          err_q, err_d;

    logic is_idle, grant_ld, grant_slot, rom_blk;

    assign is_idle    = (state_q == S_IDLE);
    assign grant_ld   = is_idle && i_LD_VALID && (!pend_q || (streak_q == STREAK_MAX));
    assign grant_slot = is_idle && pend_q && !grant_ld;

`ifdef Y8960_MEMARB_ROMWP_EN
    // Slot writes into the lower half (ROM) complete locally without touching memory.
    assign rom_blk = pend_wr_q && !pend_addr_q[18];
`else
    assign rom_blk = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_wr_d    = pend_wr_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        streak_d     = streak_q;
        owner_ld_d   = owner_ld_q;
        tmo_d        = tmo_q;
        mem_rq_d     = 1'b0;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        slot_rdata_d = slot_rdata_q;
        slot_done_d  = 1'b0;
        slot_ovf_d   = slot_ovf_q;
        ld_rdata_d   = ld_rdata_q;
        ld_ready_d   = 1'b0;
        ld_rvalid_d  = 1'b0;
        err_d        = err_q;

        // A pulse landing on the grant edge refills the slot just being vacated.
        if (i_SLOT_RQ) begin
            if (!pend_q || grant_slot) begin
                pend_d       = 1'b1;
                pend_wr_d    = i_SLOT_WR;
                pend_addr_d  = i_SLOT_ADDR;
                pend_wdata_d = i_SLOT_WDATA;
            end else begin
                slot_ovf_d = 1'b1;
            end
        end else if (grant_slot) begin
            pend_d = 1'b0;
        end

        if (grant_slot) begin
            if (!i_LD_VALID) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + 1'b1;
            end
            if (rom_blk) begin
                slot_done_d = 1'b1;
            end else begin
                state_d     = S_BUSY;
                mem_rq_d    = 1'b1;
                mem_wr_d    = pend_wr_q;
                mem_addr_d  = pend_addr_q;
                mem_wdata_d = pend_wdata_q;
                owner_ld_d  = 1'b0;
                tmo_d       = '0;
            end
        end else if (grant_ld) begin
            streak_d    = '0;
            state_d     = S_BUSY;
            mem_rq_d    = 1'b1;
            mem_wr_d    = i_LD_WR;
            mem_addr_d  = i_LD_ADDR;
            mem_wdata_d = i_LD_WDATA;
            owner_ld_d  = 1'b1;
            tmo_d       = '0;
            ld_ready_d  = 1'b1;
        end else if (state_q == S_BUSY) begin
            // RDY coinciding with the command strobe belongs to no transaction.
            if (i_MEM_RDY && !mem_rq_q) begin
                state_d = S_IDLE;
                if (owner_ld_q) begin
                    ld_rvalid_d = 1'b1;
                    if (!mem_wr_q) ld_rdata_d = i_MEM_RDATA;
                end else begin
                    slot_done_d = 1'b1;
                    if (!mem_wr_q) slot_rdata_d = i_MEM_RDATA;
                end
            end else if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                if (owner_ld_q) begin
                    ld_rvalid_d = 1'b1;
                    ld_rdata_d  = 8'hFF;
                end else begin
                    slot_done_d  = 1'b1;
                    slot_rdata_d = 8'hFF;
                end
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q      <= S_IDLE;
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            streak_q     <= '0;
            owner_ld_q   <= 1'b0;
            tmo_q        <= '0;
            mem_rq_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            slot_rdata_q <= 8'hFF;
            slot_done_q  <= 1'b0;
            slot_ovf_q   <= 1'b0;
            ld_rdata_q   <= 8'hFF;
            ld_ready_q   <= 1'b0;
            ld_rvalid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_wr_q    <= pend_wr_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            streak_q     <= streak_d;
            owner_ld_q   <= owner_ld_d;
            tmo_q        <= tmo_d;
            mem_rq_q     <= mem_rq_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            slot_rdata_q <= slot_rdata_d;
            slot_done_q  <= slot_done_d;
            slot_ovf_q   <= slot_ovf_d;
            ld_rdata_q   <= ld_rdata_d;
            ld_ready_q   <= ld_ready_d;
            ld_rvalid_q  <= ld_rvalid_d;
            err_q        <= err_d;
        end
    end

    assign o_SLOT_RDATA = slot_rdata_q;
    assign o_SLOT_DONE  = slot_done_q;
    assign o_SLOT_OVF   = slot_ovf_q;
    assign o_LD_READY   = ld_ready_q;
    assign o_LD_RDATA   = ld_rdata_q;
    assign o_LD_RVALID  = ld_rvalid_q;
    assign o_MEM_RQ     = mem_rq_q;
    assign o_MEM_WR     = mem_wr_q;
    assign o_MEM_ADDR   = mem_addr_q;
    assign o_MEM_WDATA  = mem_wdata_q;
    assign o_BUSY       = (state_q == S_BUSY);
    assign o_ERR        = err_q;

endmodule

// File: tb/tb_y8960_mem_arbiter.sv
// Directed bench for y8960_mem_arbiter (LOAD_MAXWAIT=4, TIMEOUT=8).
module tb_y8960_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slot_rq = 1'b0, slot_wr = 1'b0;
    logic [18:0] slot_addr = '0;
    logic [7:0]  slot_wdata = '0;
    logic        ld_valid = 1'b0, ld_wr = 1'b0;
    logic [18:0] ld_addr = '0;
    logic [7:0]  ld_wdata = '0;
    logic        phy_auto = 1'b0, man_rdy = 1'b0;
    logic [7:0]  man_rdata = '0;
    logic        mem_rdy;
    logic [7:0]  mem_rdata;

    logic [7:0]  o_slot_rdata, o_ld_rdata, o_mem_wdata;
    logic        o_slot_done, o_slot_ovf, o_ld_ready, o_ld_rvalid;
    logic        o_mem_rq, o_mem_wr, o_busy, o_err;
    logic [18:0] o_mem_addr;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    // Zero-wait PHY: answers in the cycle after the command strobe, data derived from the address.
    assign mem_rdy   = phy_auto ? (o_busy && !o_mem_rq) : man_rdy;
    assign mem_rdata = phy_auto ? (o_mem_addr[7:0] ^ 8'hA5) : man_rdata;

    y8960_mem_arbiter #(.LOAD_MAXWAIT(4), .TIMEOUT(8)) dut (
        .i_EMUCLK(clk), .i_RST_n(rst_n),
        .i_SLOT_RQ(slot_rq), .i_SLOT_WR(slot_wr), .i_SLOT_ADDR(slot_addr), .i_SLOT_WDATA(slot_wdata),
        .o_SLOT_RDATA(o_slot_rdata), .o_SLOT_DONE(o_slot_done), .o_SLOT_OVF(o_slot_ovf),
        .i_LD_VALID(ld_valid), .o_LD_READY(o_ld_ready), .i_LD_WR(ld_wr), .i_LD_ADDR(ld_addr),
        .i_LD_WDATA(ld_wdata), .o_LD_RDATA(o_ld_rdata), .o_LD_RVALID(o_ld_rvalid),
        .o_MEM_RQ(o_mem_rq), .o_MEM_WR(o_mem_wr), .o_MEM_ADDR(o_mem_addr), .o_MEM_WDATA(o_mem_wdata),
        .i_MEM_RDATA(mem_rdata), .i_MEM_RDY(mem_rdy), .o_BUSY(o_busy), .o_ERR(o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slot_pulse(input logic wr, input logic [18:0] addr, input logic [7:0] wd);
        slot_rq = 1'b1; slot_wr = wr; slot_addr = addr; slot_wdata = wd;
        tick();
        slot_rq = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic ld);
        int n = 0;
        while (!(ld ? o_ld_rvalid : o_slot_done) && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(ld ? o_ld_rvalid : o_slot_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic got [10];
        int   ng;
        int   nrq;
        logic [18:0] last_addr;
        logic saw_done;

        // Reset state
        tick(); tick();
        chk("rst_slot_rdata", 32'(o_slot_rdata), 32'hFF);
        chk("rst_ld_rdata", 32'(o_ld_rdata), 32'hFF);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_mem_rq", 32'(o_mem_rq), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_ovf_err", 32'({o_slot_ovf, o_err}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Slot read, RDY raised already during the strobe cycle (must be ignored there)
        slot_pulse(1'b0, 19'h41234, 8'h00);
        chk("rd_idle_after_pulse", 32'(o_busy), 32'd0);
        tick();
        chk("rd_mem_rq", 32'(o_mem_rq), 32'd1);
        chk("rd_mem_addr", 32'(o_mem_addr), 32'h41234);
        chk("rd_mem_wr", 32'(o_mem_wr), 32'd0);
        man_rdy = 1'b1; man_rdata = 8'h5A;
        tick();
        chk("rd_rdy_in_rq_ignored", 32'({o_slot_done, o_busy, o_mem_rq}), 32'b010);
        tick();
        chk("rd_done_3_edges", 32'(o_slot_done), 32'd1);
        chk("rd_rdata", 32'(o_slot_rdata), 32'h5A);
        man_rdy = 1'b0;
        tick();
        chk("rd_done_one_cycle", 32'({o_slot_done, o_busy}), 32'b00);

        // Fairness: slot kept pending, loader waiting -> S S S S L repeating
        phy_auto = 1'b1;
        slot_rq = 1'b1; slot_wr = 1'b0; slot_addr = 19'h40000;
        tick();
        ld_valid = 1'b1; ld_wr = 1'b0; ld_addr = 19'h20000;
        ng = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_mem_rq) begin
                if (ng < 10) got[ng] = o_ld_ready;
                ng++;
            end
        end
        chk("arb_grant_count", 32'(ng >= 10), 32'd1);
        for (int k = 0; k < 10; k++)
            chk($sformatf("arb_grant_%0d_is_loader", k), 32'(got[k]), 32'((k % 5) == 4));
        slot_rq = 1'b0; ld_valid = 1'b0;
        repeat (6) tick();
        chk("arb_ovf_sticky", 32'(o_slot_ovf), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arb_rst_clears_ovf", 32'(o_slot_ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        // Overflow: A busy, B pending, C dropped
        phy_auto = 1'b0;
        slot_pulse(1'b0, 19'h00100, 8'h00);
        tick();
        chk("ovf_a_granted", 32'({o_mem_rq, o_mem_addr}), {12'd0, 1'b1, 19'h00100});
        slot_rq = 1'b1; slot_addr = 19'h00200;
        tick();
        chk("ovf_not_yet", 32'(o_slot_ovf), 32'd0);
        slot_addr = 19'h00300;
        tick();
        slot_rq = 1'b0;
        chk("ovf_set", 32'(o_slot_ovf), 32'd1);
        chk("ovf_addr_held", 32'(o_mem_addr), 32'h00100);
        phy_auto = 1'b1;
        nrq = 0; last_addr = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_mem_rq) begin
                nrq++;
                last_addr = o_mem_addr;
            end
        end
        chk("ovf_one_cmd", 32'(nrq), 32'd1);
        chk("ovf_cmd_addr", 32'(last_addr), 32'h00200);
        chk("ovf_b_rdata", 32'(o_slot_rdata), 32'hA5);
        chk("ovf_still_set", 32'(o_slot_ovf), 32'd1);

        // RDY on the 8th BUSY edge wins over the timeout
        phy_auto = 1'b0;
        slot_pulse(1'b0, 19'h0ABCD, 8'h00);
        tick();
        repeat (7) tick();
        chk("late_rdy_still_busy", 32'({o_busy, o_slot_done}), 32'b10);
        man_rdy = 1'b1; man_rdata = 8'h3C;
        tick();
        man_rdy = 1'b0;
        chk("late_rdy_done", 32'(o_slot_done), 32'd1);
        chk("late_rdy_rdata", 32'(o_slot_rdata), 32'h3C);
        chk("late_rdy_no_err", 32'({o_err, o_busy}), 32'b00);

        // Loader read then loader write to the ROM region
        ld_valid = 1'b1; ld_wr = 1'b0; ld_addr = 19'h55555;
        tick();
        chk("ld_ready", 32'({o_ld_ready, o_mem_rq}), 32'b11);
        chk("ld_mem_addr", 32'(o_mem_addr), 32'h55555);
        ld_valid = 1'b0;
        tick();
        chk("ld_ready_one_cycle", 32'(o_ld_ready), 32'd0);
        man_rdy = 1'b1; man_rdata = 8'h77;
        tick();
        man_rdy = 1'b0;
        chk("ld_rvalid", 32'({o_ld_rvalid, o_slot_done}), 32'b10);
        chk("ld_rdata", 32'(o_ld_rdata), 32'h77);
        tick();
        ld_valid = 1'b1; ld_wr = 1'b1; ld_addr = 19'h01000; ld_wdata = 8'h99;
        tick();
        ld_valid = 1'b0;
        chk("ldw_forwarded", 32'({o_mem_rq, o_mem_wr, o_mem_wdata}), 32'h399);
        chk("ldw_addr", 32'(o_mem_addr), 32'h01000);
        phy_auto = 1'b1;
        wait_done("ldw_rvalid", 1'b1);
        chk("ldw_rdata_kept", 32'(o_ld_rdata), 32'h77);
        tick();

        // Slot writes: ROM region and RAM region
        slot_pulse(1'b1, 19'h01000, 8'h11);
        tick();
`ifdef Y8960_MEMARB_ROMWP_EN
        chk("romw_blocked", 32'({o_mem_rq, o_busy, o_slot_done}), 32'b001);
        tick();
        chk("romw_done_one_cycle", 32'(o_slot_done), 32'd0);
`else
        chk("romw_forwarded", 32'({o_mem_rq, o_mem_wr, o_mem_addr}), {12'd0, 2'b11, 19'h01000});
        wait_done("romw_done", 1'b0);
`endif
        tick();
        slot_pulse(1'b1, 19'h41000, 8'h22);
        tick();
        chk("ramw_forwarded", 32'({o_mem_rq, o_mem_wr, o_mem_wdata}), 32'h322);
        chk("ramw_addr", 32'(o_mem_addr), 32'h41000);
        wait_done("ramw_done", 1'b0);
        chk("ramw_rdata_kept", 32'(o_slot_rdata), 32'h3C);
        tick();

        // Timeout with no RDY
        phy_auto = 1'b0;
        slot_pulse(1'b0, 19'h12345, 8'h00);
        tick();
        repeat (7) tick();
        chk("tmo_still_busy", 32'({o_busy, o_slot_done, o_err}), 32'b100);
        tick();
        chk("tmo_done", 32'({o_slot_done, o_busy}), 32'b10);
        chk("tmo_rdata_ff", 32'(o_slot_rdata), 32'hFF);
        chk("tmo_err", 32'(o_err), 32'd1);
        tick();

        // Reset mid-BUSY
        phy_auto = 1'b1;
        slot_pulse(1'b0, 19'h000C3, 8'h00);
        wait_done("pre_rst_done", 1'b0);
        chk("pre_rst_rdata", 32'(o_slot_rdata), 32'h66);
        tick();
        phy_auto = 1'b0;
        slot_pulse(1'b0, 19'h7FFFF, 8'h00);
        tick();
        tick();
        chk("mid_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_cleared", 32'({o_busy, o_mem_rq, o_err}), 32'b000);
        chk("rst_mem_addr_cleared", 32'(o_mem_addr), 32'd0);
        chk("rst_rdata_ff", 32'({o_slot_rdata, o_ld_rdata}), 32'hFFFF);
        #1;
        rst_n = 1'b1;
        phy_auto = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            tick();
            saw_done = saw_done | o_slot_done;
        end
        chk("rst_no_done", 32'(saw_done), 32'd0);
        slot_pulse(1'b0, 19'h000F0, 8'h00);
        wait_done("post_rst_done", 1'b0);
        chk("post_rst_rdata", 32'(o_slot_rdata), 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
